// File: rtl/histoframe_accel_mac_pipe.sv
// Pipelined multiply / accumulate with saturating output. Latency NUM_STAGE ce-cycles in both modes;
// no backpressure: ce low freezes every stage, the accumulator and the output registers.
module histoframe_accel_mac_pipe #(
    parameter int A_WIDTH     = 16,
    parameter int B_WIDTH     = 16,
    parameter int ACC_WIDTH   = 40,
    parameter int OUT_WIDTH   = 32,
    parameter int OUT_SHIFT   = 0,
    parameter int NUM_STAGE   = 4,
    parameter int SIGNED_MODE = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ce,
    input  logic [A_WIDTH-1:0]   din0,
    input  logic [B_WIDTH-1:0]   din1,
    input  logic                 in_valid,
    input  logic                 in_mode,
    input  logic                 in_last,
    output logic [OUT_WIDTH-1:0] dout,
    output logic                 dout_valid,
    output logic                 dout_sat
);
    localparam int PW  = A_WIDTH + B_WIDTH;
    localparam int NP  = NUM_STAGE - 1;
    localparam int EXT = ACC_WIDTH - PW;

    logic [PW-1:0]        mult;
    logic [PW-1:0]        prod_q [NP];
    logic [NP-1:0]        vld_q;
    logic [NP-1:0]        mode_q;
    logic [NP-1:0]        last_q;

    logic [ACC_WIDTH-1:0] acc_q;
    logic                 group_open_q;
    logic [OUT_WIDTH-1:0] dout_q;
    logic                 dout_valid_q;
    logic                 dout_sat_q;

    logic [ACC_WIDTH-1:0] prod_ext;
    logic [ACC_WIDTH-1:0] acc_d;
    logic [ACC_WIDTH-1:0] res;
    logic [ACC_WIDTH-1:0] shifted;
    logic [OUT_WIDTH-1:0] sat_val;
    logic                 sat_flag;

    // Operands extended to the full product width: the low PW bits of the
    // product are then correct for both signed and unsigned interpretation.
    generate
        if (SIGNED_MODE != 0) begin : g_sext
            assign mult = {{B_WIDTH{din0[A_WIDTH-1]}}, din0} * {{A_WIDTH{din1[B_WIDTH-1]}}, din1};
        end else begin : g_zext
            assign mult = {{B_WIDTH{1'b0}}, din0} * {{A_WIDTH{1'b0}}, din1};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q  <= '0;
            mode_q <= '0;
            last_q <= '0;
            for (int i = 0; i < NP; i++) prod_q[i] <= '0;
        end else if (ce) begin
            vld_q     <= {vld_q[NP-2:0], in_valid};
            mode_q    <= {mode_q[NP-2:0], in_mode};
            last_q    <= {last_q[NP-2:0], in_last};
            prod_q[0] <= mult;
            for (int i = 1; i < NP; i++) prod_q[i] <= prod_q[i-1];
        end
    end

    assign prod_ext = {{EXT{(SIGNED_MODE != 0) && prod_q[NP-1][PW-1]}}, prod_q[NP-1]};
    assign acc_d    = group_open_q ? acc_q + prod_ext : prod_ext;
    assign res      = mode_q[NP-1] ? acc_d : prod_ext;

    generate
        if (SIGNED_MODE != 0) begin : g_ashr
            assign shifted = $signed(res) >>> OUT_SHIFT;
        end else begin : g_lshr
            assign shifted = res >> OUT_SHIFT;
        end
    endgenerate

    // Out of range when the bits above the output width are not a pure extension.
    always_comb begin
        sat_val  = shifted[OUT_WIDTH-1:0];
        sat_flag = 1'b0;
        if (SIGNED_MODE != 0) begin
            if (!((&shifted[ACC_WIDTH-1:OUT_WIDTH-1]) || !(|shifted[ACC_WIDTH-1:OUT_WIDTH-1]))) begin
                sat_flag = 1'b1;
                sat_val  = shifted[ACC_WIDTH-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}}
                                                : {1'b0, {(OUT_WIDTH-1){1'b1}}};
            end
        end else if (|shifted[ACC_WIDTH-1:OUT_WIDTH]) begin
            sat_flag = 1'b1;
            sat_val  = '1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q        <= '0;
            group_open_q <= 1'b0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            dout_sat_q   <= 1'b0;
        end else if (ce) begin
            dout_valid_q <= 1'b0;
            if (vld_q[NP-1]) begin
                if (mode_q[NP-1]) begin
                    acc_q        <= acc_d;
                    group_open_q <= !last_q[NP-1];
                end
                if (!mode_q[NP-1] || last_q[NP-1]) begin
                    dout_q       <= sat_val;
                    dout_sat_q   <= sat_flag;
                    dout_valid_q <= 1'b1;
                end
            end
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign dout_sat   = dout_sat_q;
endmodule

// File: tb/tb_histoframe_accel_mac_pipe.sv
// Directed bench: default (unsigned) instance plus a signed 16-bit-output instance on shared inputs.
module tb_histoframe_accel_mac_pipe;
    logic        clk = 1'b0;
    logic        reset, ce, in_valid, in_mode, in_last;
    logic [15:0] din0, din1;
    logic [31:0] dout_u;
    logic        vu, su;
    logic [15:0] dout_s;
    logic        vs, ss;
    int          n_pass = 0;
    int          n_total = 0;

    always #5 clk = ~clk;

    histoframe_accel_mac_pipe u_dut (
        .clk(clk), .reset(reset), .ce(ce), .din0(din0), .din1(din1),
        .in_valid(in_valid), .in_mode(in_mode), .in_last(in_last),
        .dout(dout_u), .dout_valid(vu), .dout_sat(su)
    );

    histoframe_accel_mac_pipe #(.OUT_WIDTH(16), .SIGNED_MODE(1)) u_sdut (
        .clk(clk), .reset(reset), .ce(ce), .din0(din0), .din1(din1),
        .in_valid(in_valid), .in_mode(in_mode), .in_last(in_last),
        .dout(dout_s), .dout_valid(vs), .dout_sat(ss)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic v, input logic m, input logic l,
                        input logic [15:0] a, input logic [15:0] b);
        in_valid = v; in_mode = m; in_last = l; din0 = a; din1 = b;
    endtask

    task automatic test_reset;
        reset = 1'b1; ce = 1'b0;
        beat(1'b1, 1'b0, 1'b0, 16'd7, 16'd7);
        step; step;
        n_total++; if (vu !== 1'b0)       $display("FAIL reset_vld got %b exp 0", vu); else n_pass++;
        n_total++; if (dout_u !== 32'd0)  $display("FAIL reset_dout got %h exp 0", dout_u); else n_pass++;
        n_total++; if (su !== 1'b0)       $display("FAIL reset_sat got %b exp 0", su); else n_pass++;
        n_total++; if ({vs, ss, dout_s} !== 18'd0) $display("FAIL reset_signed got %h exp 0", {vs, ss, dout_s}); else n_pass++;
        beat(1'b0, 1'b0, 1'b0, 16'd0, 16'd0);
        reset = 1'b0; ce = 1'b1;
        step; step; step; step;
        n_total++; if (vu !== 1'b0)       $display("FAIL reset_flush got %b exp 0", vu); else n_pass++;
    endtask

    task automatic test_mode0;
        beat(1'b1, 1'b0, 1'b0, 16'hFFFF, 16'hFFFF);
        for (int k = 1; k <= 4; k++) begin
            step;
            if (k == 1) beat(1'b0, 1'b0, 1'b0, 16'd0, 16'd0);
            if (k < 4) begin
                n_total++; if (vu !== 1'b0) $display("FAIL mode0_early k=%0d got %b exp 0", k, vu); else n_pass++;
            end
        end
        n_total++; if (vu !== 1'b1)             $display("FAIL mode0_vld got %b exp 1", vu); else n_pass++;
        n_total++; if (dout_u !== 32'hFFFE0001) $display("FAIL mode0_dout got %h exp fffe0001", dout_u); else n_pass++;
        n_total++; if (su !== 1'b0)             $display("FAIL mode0_sat got %b exp 0", su); else n_pass++;
        step;
        n_total++; if (vu !== 1'b0)             $display("FAIL mode0_pulse got %b exp 0", vu); else n_pass++;
        n_total++; if (dout_u !== 32'hFFFE0001) $display("FAIL mode0_hold got %h exp fffe0001", dout_u); else n_pass++;
    endtask

    task automatic test_accum;
        logic [15:0] a [3] = '{16'd3, 16'd7, 16'd10};
        logic [15:0] b [3] = '{16'd5, 16'd2, 16'd10};
        logic        l [3] = '{1'b0, 1'b0, 1'b1};
        for (int k = 0; k < 7; k++) begin
            if (k < 3) beat(1'b1, 1'b1, l[k], a[k], b[k]);
            else       beat(1'b0, 1'b0, 1'b0, 16'd0, 16'd0);
            step;
            if (k < 5) begin
                n_total++; if (vu !== 1'b0) $display("FAIL accum_vld k=%0d got %b exp 0", k, vu); else n_pass++;
            end else if (k == 5) begin
                n_total++; if ({vu, su, dout_u} !== {2'b10, 32'd129}) $display("FAIL accum_dout got v=%b s=%b d=%0d exp v=1 s=0 d=129", vu, su, dout_u); else n_pass++;
            end else begin
                n_total++; if (vu !== 1'b0) $display("FAIL accum_after got %b exp 0", vu); else n_pass++;
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [15:0] a  [5] = '{16'd1, 16'd3, 16'd2, 16'd2, 16'd5};
        logic [15:0] b  [5] = '{16'd2, 16'd4, 16'd2, 16'd2, 16'd6};
        logic        m  [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic        l  [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        logic        ev [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        logic [31:0] ed [5] = '{32'd2, 32'd12, 32'd0, 32'd8, 32'd30};
        for (int k = 0; k < 8; k++) begin
            if (k < 5) beat(1'b1, m[k], l[k], a[k], b[k]);
            else       beat(1'b0, 1'b0, 1'b0, 16'd0, 16'd0);
            step;
            if (k >= 3) begin
                n_total++; if (vu !== ev[k-3]) $display("FAIL b2b_vld slot=%0d got %b exp %b", k-3, vu, ev[k-3]); else n_pass++;
                if (ev[k-3]) begin
                    n_total++; if (dout_u !== ed[k-3]) $display("FAIL b2b_dout slot=%0d got %0d exp %0d", k-3, dout_u, ed[k-3]); else n_pass++;
                end
            end
        end
        step;
    endtask

    task automatic test_interleave;
        logic [15:0] a  [3] = '{16'd1, 16'd2, 16'd1};
        logic        m  [3] = '{1'b1, 1'b0, 1'b1};
        logic        l  [3] = '{1'b0, 1'b0, 1'b1};
        logic        ev [3] = '{1'b0, 1'b1, 1'b1};
        logic [31:0] ed [3] = '{32'd0, 32'd4, 32'd2};
        for (int k = 0; k < 6; k++) begin
            if (k < 3) beat(1'b1, m[k], l[k], a[k], a[k]);
            else       beat(1'b0, 1'b0, 1'b0, 16'd0, 16'd0);
            step;
            if (k >= 3) begin
                n_total++; if (vu !== ev[k-3]) $display("FAIL ilv_vld slot=%0d got %b exp %b", k-3, vu, ev[k-3]); else n_pass++;
                if (ev[k-3]) begin
                    n_total++; if (dout_u !== ed[k-3]) $display("FAIL ilv_dout slot=%0d got %0d exp %0d", k-3, dout_u, ed[k-3]); else n_pass++;
                end
            end
        end
        step;
    endtask

    task automatic test_ce;
        ce = 1'b1;
        beat(1'b1, 1'b0, 1'b0, 16'hFFFF, 16'hFFFF);
        step;
        ce = 1'b0;
        beat(1'b1, 1'b0, 1'b0, 16'd9, 16'd9);
        step; step;
        ce = 1'b1;
        beat(1'b0, 1'b0, 1'b0, 16'd0, 16'd0);
        for (int k = 0; k < 2; k++) begin
            step;
            n_total++; if (vu !== 1'b0) $display("FAIL ce_early k=%0d got %b exp 0", k, vu); else n_pass++;
        end
        step;
        n_total++; if ({vu, dout_u} !== {1'b1, 32'hFFFE0001}) $display("FAIL ce_dout got v=%b d=%h exp v=1 d=fffe0001", vu, dout_u); else n_pass++;
        ce = 1'b0;
        step;
        n_total++; if ({vu, dout_u} !== {1'b1, 32'hFFFE0001}) $display("FAIL ce_freeze got v=%b d=%h exp v=1 d=fffe0001", vu, dout_u); else n_pass++;
        ce = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step;
            n_total++; if (vu !== 1'b0) $display("FAIL ce_ignored k=%0d got %b exp 0", k, vu); else n_pass++;
        end
    endtask

    task automatic test_signed;
        logic [15:0] a  [3] = '{16'h8000, 16'h8000, 16'hFFFD};
        logic [15:0] b  [3] = '{16'h8000, 16'h7FFF, 16'h0007};
        logic [15:0] es [3] = '{16'h7FFF, 16'h8000, 16'hFFEB};
        logic        eq [3] = '{1'b1, 1'b1, 1'b0};
        logic [31:0] eu [3] = '{32'h40000000, 32'h3FFF8000, 32'h0006FFEB};
        for (int k = 0; k < 6; k++) begin
            if (k < 3) beat(1'b1, 1'b0, 1'b0, a[k], b[k]);
            else       beat(1'b0, 1'b0, 1'b0, 16'd0, 16'd0);
            step;
            if (k >= 3) begin
                n_total++; if ({vs, ss, dout_s} !== {1'b1, eq[k-3], es[k-3]}) $display("FAIL signed slot=%0d got v=%b s=%b d=%h exp v=1 s=%b d=%h", k-3, vs, ss, dout_s, eq[k-3], es[k-3]); else n_pass++;
                n_total++; if ({vu, su, dout_u} !== {2'b10, eu[k-3]}) $display("FAIL unsigned slot=%0d got v=%b s=%b d=%h exp v=1 s=0 d=%h", k-3, vu, su, dout_u, eu[k-3]); else n_pass++;
            end
        end
        step;
    endtask

    task automatic test_unsigned_sat;
        for (int k = 0; k < 5; k++) begin
            if (k < 2) beat(1'b1, 1'b1, k == 1, 16'hFFFF, 16'hFFFF);
            else       beat(1'b0, 1'b0, 1'b0, 16'd0, 16'd0);
            step;
        end
        n_total++; if ({vu, su, dout_u} !== {2'b11, 32'hFFFFFFFF}) $display("FAIL usat got v=%b s=%b d=%h exp v=1 s=1 d=ffffffff", vu, su, dout_u); else n_pass++;
        n_total++; if ({vs, ss, dout_s} !== {2'b10, 16'd2}) $display("FAIL usat_signed got v=%b s=%b d=%h exp v=1 s=0 d=0002", vs, ss, dout_s); else n_pass++;
        step;
    endtask

    task automatic test_reset_mid;
        // Beat still inside the multiply pipe when reset hits.
        beat(1'b1, 1'b1, 1'b0, 16'd4, 16'd4);
        step;
        beat(1'b0, 1'b0, 1'b0, 16'd0, 16'd0);
        reset = 1'b1;
        step;
        reset = 1'b0;
        n_total++; if ({vu, su, dout_u} !== 34'd0) $display("FAIL rst_mid_clear got v=%b s=%b d=%h exp 0", vu, su, dout_u); else n_pass++;
        beat(1'b1, 1'b1, 1'b1, 16'd2, 16'd3);
        for (int k = 0; k < 4; k++) begin
            step;
            beat(1'b0, 1'b0, 1'b0, 16'd0, 16'd0);
            if (k < 3) begin
                n_total++; if (vu !== 1'b0) $display("FAIL rst_mid_vld k=%0d got %b exp 0", k, vu); else n_pass++;
            end
        end
        n_total++; if ({vu, dout_u} !== {1'b1, 32'd6}) $display("FAIL rst_mid_dout got v=%b d=%0d exp v=1 d=6", vu, dout_u); else n_pass++;
        // Group fully opened in the accumulator before reset.
        beat(1'b1, 1'b1, 1'b0, 16'd4, 16'd4);
        step;
        beat(1'b0, 1'b0, 1'b0, 16'd0, 16'd0);
        step; step; step; step;
        reset = 1'b1;
        step;
        reset = 1'b0;
        beat(1'b1, 1'b1, 1'b1, 16'd2, 16'd3);
        step;
        beat(1'b0, 1'b0, 1'b0, 16'd0, 16'd0);
        step; step; step;
        n_total++; if ({vu, dout_u} !== {1'b1, 32'd6}) $display("FAIL rst_open_dout got v=%b d=%0d exp v=1 d=6", vu, dout_u); else n_pass++;
        step;
    endtask

    initial begin
        reset = 1'b1; ce = 1'b1;
        beat(1'b0, 1'b0, 1'b0, 16'd0, 16'd0);
        test_reset;
        test_mode0;
        test_accum;
        test_back_to_back;
        test_interleave;
        test_ce;
        test_signed;
        test_unsigned_sat;
        test_reset_mid;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/histoframe_accel_mac_pipe.md
HISTOFRAME_ACCEL_MAC_PIPE -- requirements
Module: histoframe_accel_mac_pipe

Interface
REQ-001 SHALL provide parameter A_WIDTH, default 16, width of operand din0.
REQ-002 SHALL provide parameter B_WIDTH, default 16, width of operand din1.
REQ-003 SHALL provide parameter ACC_WIDTH, default 40, internal accumulator width; legal range is at least A_WIDTH+B_WIDTH+1.
REQ-004 SHALL provide parameter OUT_WIDTH, default 32, width of dout.
REQ-005 SHALL provide parameter OUT_SHIFT, default 0, arithmetic right shift applied before output narrowing; legal range 0..ACC_WIDTH-1.
REQ-006 SHALL provide parameter NUM_STAGE, default 4, total latency in ce-enabled cycles; legal range 3..8.
REQ-007 SHALL provide parameter SIGNED_MODE, default 0; 0 treats both operands and dout as unsigned, 1 treats them as two's complement.
REQ-008 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-009 SHALL have port reset, input, 1 bit: reset is synchronous and active-high.
REQ-010 SHALL have port ce, input, 1 bit: global pipeline enable; when low, all state holds.
REQ-011 SHALL have port din0, input, A_WIDTH bits: operand A.
REQ-012 SHALL have port din1, input, B_WIDTH bits: operand B.
REQ-013 SHALL have port in_valid, input, 1 bit: the beat is accepted when in_valid and ce are both high.
REQ-014 SHALL have port in_mode, input, 1 bit: 0 is multiply pass-through, 1 is accumulate; the value travels with the beat.
REQ-015 SHALL have port in_last, input, 1 bit: marks the final beat of an accumulate group; ignored when in_mode=0.
REQ-016 SHALL have port dout, output, OUT_WIDTH bits: result.
REQ-017 SHALL have port dout_valid, output, 1 bit: result qualifier.
REQ-018 SHALL have port dout_sat, output, 1 bit: dout was clamped; meaningful only while dout_valid is high.

Function
REQ-019 Product SHALL be full precision (A_WIDTH+B_WIDTH bits), sign- or zero-extended to ACC_WIDTH according to SIGNED_MODE.
REQ-020 Multiply pipeline SHALL be NUM_STAGE-1 registered stages carrying valid, mode and last alongside data; the final stage is the accumulate/output stage.
REQ-021 A beat accepted at ce-cycle n SHALL produce its output (if any) at ce-cycle n+NUM_STAGE, in both modes; cycles with ce low do not count.
REQ-022 Mode 0 beat: dout SHALL equal sat(product >>> OUT_SHIFT), with dout_valid=1 for one ce-cycle; the accumulator and group state are untouched.
REQ-023 Mode 1 beat: acc SHALL become product if group_open=0, otherwise acc+product (ACC_WIDTH wrap); group_open is then set to 1.
REQ-024 Mode 1 beat with last=1: dout SHALL equal sat(new acc >>> OUT_SHIFT), dout_valid=1, and group_open is cleared; mode 1 beats with last=0 SHALL drive dout_valid=0.
REQ-025 Mode 0 beats interleaved inside an open group SHALL pass through per REQ-022 without closing the group.
REQ-026 sat(): if the shifted value exceeds the OUT_WIDTH range (unsigned 0..2^OUT_WIDTH-1; signed -2^(OUT_WIDTH-1)..2^(OUT_WIDTH-1)-1), dout SHALL be clamped to the nearest bound with dout_sat=1; otherwise dout_sat=0.
REQ-027 Stage with no valid beat SHALL drive dout_valid=0; dout and dout_sat SHALL hold their last values.
REQ-028 ce low SHALL freeze all stages, accumulator, group_open, dout, dout_valid and dout_sat; in_valid SHALL be ignored.
REQ-029 Back-to-back beats every ce-cycle SHALL be sustained with no bubbles, including consecutive accumulate groups.
REQ-030 A single-beat group (mode 1, last=1, group_open=0) SHALL output sat(product >>> OUT_SHIFT).

Reset
REQ-031 reset high at a clk edge SHALL clear all pipeline valids, the accumulator, group_open, dout, dout_valid and dout_sat to 0, regardless of ce.
REQ-032 Beats in flight and open groups at reset SHALL be discarded with no output; the first output after reset SHALL come from a beat accepted after reset deasserts.

Verification
REQ-033 Defaults, mode 0, din0=65535, din1=65535 -> 4 cycles later dout=0xFFFE0001, dout_valid=1, dout_sat=0.
REQ-034 Defaults, mode 1, beats (3,5),(7,2),(10,10,last) on consecutive cycles -> single dout=129 four cycles after the last beat; dout_valid low on the two preceding output slots.
REQ-035 ce toggled 1,0,0,1,... during REQ-033 stream -> output delayed exactly by the 2 low cycles, with value unchanged.
REQ-036 SIGNED_MODE=1, OUT_WIDTH=16, mode 0, din0=-32768, din1=-32768 -> dout=32767, dout_sat=1.
REQ-037 Reset asserted one cycle after a mode 1 beat (4,4) with no last; then new group (2,3,last) -> only dout=6, no residue of 16.
REQ-038 Mode 0 beat (2,2) between group beats (1,1) and (1,1,last) -> outputs 4, then 2, in acceptance order.
